// File: rtl/successive_sum_decoder_pkg.sv
// Shared definitions for the successive-difference encoder and the successive-sum decoder.
package successive_sum_decoder_pkg;

    localparam int N_DEF     = 9;
    localparam int W_DEF     = 8;
    localparam int IDX_W     = 4;
    localparam int OUT_PORTS = 9;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/successive_sum_decoder_if.sv
// Delta-in / frame-out bus of the successive-sum decoder.
interface successive_sum_decoder_if
    import successive_sum_decoder_pkg::*;
#(
    parameter int W = W_DEF
) ();

    // Handshake: a delta transfers on a rising edge where in_valid && in_ready;
    // a frame transfers on a rising edge where out_valid && out_ready. Each
    // valid side holds its payload stable until the transfer happens.
    logic [W-1:0] in_data;
    logic         in_first;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;

    // upstream/downstream environment
    modport master (
        output in_data, in_first, in_valid, out_ready,
        input  in_ready, out1, out2, out3, out4, out5, out6, out7, out8, out9,
        input  out_valid, frame_err
    );

    // the decoder
    modport slave (
        input  in_data, in_first, in_valid, out_ready,
        output in_ready, out1, out2, out3, out4, out5, out6, out7, out8, out9,
        output out_valid, frame_err
    );

endinterface

// File: rtl/successive_difference.sv
// Successive-difference encoder: emits sample - previous sample, or the raw sample at frame start.
module successive_difference
    import successive_sum_decoder_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] smp_data,
    input  logic         smp_first,
    input  logic         smp_fire,
    output logic [W-1:0] delta
);

    logic [W-1:0] prev_q;

    assign delta = smp_first ? smp_data : smp_data - prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (smp_fire) begin
            prev_q <= smp_data;
        end
    end

endmodule

// File: rtl/successive_sum_decoder_sample_bank.sv
// N x W sample registers with one indexed write port and a parallel read of every entry.
module sample_bank
    import successive_sum_decoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_data,
    output logic [W-1:0]     rd_data [N]
);

    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/successive_sum_decoder.sv
// Rebuilds N-sample frames from successive-difference deltas and presents each frame
// on out1..out9 until the downstream side accepts it.
module successive_sum_decoder
    import successive_sum_decoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    successive_sum_decoder_if.slave  bus,
    output state_t                   dbg_state
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             err_q, err_d;
    logic             fire;
    logic             restart;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     samples [N];
    logic [W-1:0]     pad [OUT_PORTS];

    assign bus.in_ready  = rst_n && (state_q == COLLECT);
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.frame_err = err_q;
    assign dbg_state     = state_q;
    assign fire          = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        restart = bus.in_first || (idx_q == '0);
        wr_idx  = idx_q;
        wr_data = acc_q + bus.in_data;
        case (state_q)
            COLLECT: begin
                if (fire) begin
                    wr_en = 1'b1;
                    // A flagged first delta mid-frame abandons the partial frame.
                    if (restart) begin
                        wr_idx  = '0;
                        wr_data = bus.in_data;
                        err_d   = bus.in_first && (idx_q != '0);
                    end
                    acc_d = wr_data;
                    if (wr_idx == IDX_W'(N - 1)) begin
                        state_d = PRESENT;
                        idx_d   = '0;
                    end else begin
                        idx_d = wr_idx + IDX_W'(1);
                    end
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    sample_bank #(
        .N (N),
        .W (W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_data (samples)
    );

    // Output ports beyond N read as zero.
    for (genvar k = 0; k < OUT_PORTS; k++) begin : g_pad
        if (k < N) begin : g_used
            assign pad[k] = samples[k];
        end else begin : g_unused
            assign pad[k] = '0;
        end
    end

    assign bus.out1 = pad[0];
    assign bus.out2 = pad[1];
    assign bus.out3 = pad[2];
    assign bus.out4 = pad[3];
    assign bus.out5 = pad[4];
    assign bus.out6 = pad[5];
    assign bus.out7 = pad[6];
    assign bus.out8 = pad[7];
    assign bus.out9 = pad[8];

endmodule

// File: tb/tb_successive_sum_decoder.sv
// Self-checking bench for successive_sum_decoder: prefix-sum reference model, directed frames,
// random deltas and an encoder->decoder loopback scoreboard.
module tb_successive_sum_decoder;
    import successive_sum_decoder_pkg::*;

    localparam int N       = 9;
    localparam int W       = 8;
    localparam int TIMEOUT = 200;

    typedef logic [W-1:0] frame_t [9];

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // drive variables
    logic [W-1:0] drv_data   = '0;
    logic         drv_first  = 1'b0;
    logic         drv_valid  = 1'b0;
    logic         dir_ready  = 1'b0;
    logic         rand_ready = 1'b0;
    logic         rnd_ready  = 1'b0;
    logic         lb_mode    = 1'b0;
    logic         gaps       = 1'b0;
    logic [W-1:0] enc_delta;
    state_t       dbg_state;

    successive_sum_decoder_if #(.W(W)) bus ();

    assign bus.in_data   = lb_mode ? enc_delta : drv_data;
    assign bus.in_first  = drv_first;
    assign bus.in_valid  = drv_valid;
    assign bus.out_ready = rand_ready ? rnd_ready : dir_ready;

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    successive_difference #(.W(W)) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_data  (drv_data),
        .smp_first (drv_first),
        .smp_fire  (bus.in_valid && bus.in_ready),
        .delta     (enc_delta)
    );

    successive_sum_decoder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    frame_t dut_outs;
    always_comb begin
        dut_outs = '{bus.out1, bus.out2, bus.out3, bus.out4, bus.out5,
                     bus.out6, bus.out7, bus.out8, bus.out9};
    end

    // counters and check helper
    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;

    function automatic logic [71:0] pack(input frame_t f);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = f[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_frame(input string name, input frame_t e);
        chk(name, pack(dut_outs), pack(e));
    endtask

    // reference model: frame = prefix sums of the deltas accepted since the frame start
    logic [W-1:0] m_q [$];
    logic         m_present = 1'b0;
    logic         m_err     = 1'b0;
    logic         started   = 1'b0;
    logic [W-1:0] m_sum;
    frame_t       m_out = '{default: '0};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_present = 1'b0;
            m_err     = 1'b0;
            m_out     = '{default: '0};
            started   = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_present) begin
                if (bus.out_ready) m_present = 1'b0;
            end else if (bus.in_valid) begin
                if (bus.in_first && m_q.size() != 0) begin
                    m_err = 1'b1;
                    m_q.delete();
                end
                m_q.push_back(bus.in_data);
                if (m_q.size() == N) begin
                    m_sum = '0;
                    for (int k = 0; k < N; k++) begin
                        m_sum    = m_sum + m_q[k];
                        m_out[k] = m_sum;
                    end
                    m_present = 1'b1;
                    m_q.delete();
                end
            end
        end
    end

    // loopback scoreboard
    logic [W-1:0] exp_q [$];
    frame_t       sb_frame;

    // per-cycle compare
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", bus.in_ready, rst_n && !m_present);
            chk("out_valid", bus.out_valid, m_present);
            chk("frame_err", bus.frame_err, m_err);
            chk("state", dbg_state, m_present ? PRESENT : COLLECT);
            if (m_present || m_q.size() == 0) chk("outs", pack(dut_outs), pack(m_out));
            if (lb_mode && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() < N) begin
                    chk("lb_depth", exp_q.size(), N);
                end else begin
                    for (int k = 0; k < N; k++) sb_frame[k] = exp_q.pop_front();
                    chk("loopback", pack(dut_outs), pack(sb_frame));
                end
            end
        end
        if (bus.frame_err) err_cnt++;
    end

    // driver tasks (called at posedge + 1)
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic f);
        int   g;
        logic acc;
        if (gaps) repeat ($urandom_range(0, 2)) align();
        drv_data  = d;
        drv_first = f;
        drv_valid = 1'b1;
        g   = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            align();
            g++;
        end while (!acc && g < TIMEOUT);
        drv_valid = 1'b0;
        drv_first = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input frame_t d, input logic first0);
        for (int k = 0; k < N; k++) send(d[k], (k == 0) ? first0 : 1'b0);
    endtask

    task automatic wait_valid(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < TIMEOUT) begin
            @(negedge clk);
            g++;
        end
        chk(name, bus.out_valid, 1);
    endtask

    task automatic release_frame();
        align();
        dir_ready = 1'b1;
        align();
        dir_ready = 1'b0;
    endtask

    // stimulus
    frame_t f_a  = '{8'd1, 8'd2, 8'd1, 8'd1, 8'd4, 8'd248, 8'd0, 8'd0, 8'd0};
    frame_t e_a  = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1};
    frame_t f_b  = '{8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    frame_t e_b  = '{8'd200, 8'd44, 8'd44, 8'd44, 8'd44, 8'd44, 8'd44, 8'd44, 8'd44};
    frame_t e_c  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    frame_t zero = '{default: '0};
    frame_t smp;

    initial begin
        int e0;
        int g;

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        check_frame("rst_outs", zero);
        align();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        align();

        // directed frame, out_valid one cycle after the 9th handshake
        send_frame(f_a, 1'b1);
        @(negedge clk);
        chk("frame_a_valid", bus.out_valid, 1);
        check_frame("frame_a", e_a);

        // back-pressure: in_valid held in PRESENT for 5 cycles
        align();
        drv_data  = 8'd77;
        drv_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 0);
            check_frame("hold_outs", e_a);
            align();
        end
        drv_valid = 1'b0;
        dir_ready = 1'b1;
        align();
        dir_ready = 1'b0;
        @(negedge clk);
        chk("ret_out_valid", bus.out_valid, 0);
        chk("ret_in_ready", bus.in_ready, 1);
        check_frame("ret_outs_kept", e_a);
        align();

        // wrap mod 256; first delta unflagged at idx 0 is no error
        e0 = err_cnt;
        send_frame(f_b, 1'b0);
        wait_valid("frame_b_wait");
        chk("wrap_out2", bus.out2, 44);
        check_frame("frame_b", e_b);
        chk("no_err_unflagged", err_cnt - e0, 0);
        release_frame();

        // restart on the 4th delta
        e0 = err_cnt;
        send(8'd5, 1'b1);
        send(8'd3, 1'b0);
        send(8'd2, 1'b0);
        send(8'd10, 1'b1);
        for (int k = 0; k < 8; k++) send(8'd1, 1'b0);
        wait_valid("frame_c_wait");
        check_frame("frame_c", e_c);
        chk("restart_err_pulses", err_cnt - e0, 1);

        // reset while presenting
        align();
        rst_n = 1'b0;
        align();
        @(negedge clk);
        chk("rst_present_valid", bus.out_valid, 0);
        check_frame("rst_present_outs", zero);
        align();
        rst_n = 1'b1;
        align();

        // reset after 5 deltas, then a fresh frame
        e0 = err_cnt;
        for (int k = 0; k < 5; k++) send(f_a[k], k == 0);
        rst_n = 1'b0;
        align();
        @(negedge clk);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_in_ready", bus.in_ready, 0);
        check_frame("rst_mid_outs", zero);
        align();
        rst_n = 1'b1;
        align();
        send_frame(f_a, 1'b1);
        wait_valid("frame_fresh_wait");
        check_frame("frame_fresh", e_a);
        chk("rst_no_err", err_cnt - e0, 0);
        release_frame();

        // random deltas with random restarts, gaps and back-pressure
        gaps       = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(W'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
        end
        g = 0;
        while (bus.out_valid && g < TIMEOUT) begin
            align();
            g++;
        end
        chk("rand_drain", bus.out_valid, 0);

        // encoder -> decoder loopback
        lb_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < N; k++) begin
                smp[k] = W'($urandom_range(0, 255));
                exp_q.push_back(smp[k]);
            end
            send_frame(smp, 1'b1);
        end
        g = 0;
        while (exp_q.size() != 0 && g < TIMEOUT) begin
            @(negedge clk);
            g++;
        end
        chk("lb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/successive_sum_decoder.md
SUCCESSIVE_SUM_DECODER -- requirements
Module: successive_sum_decoder

Interface
REQ-001 Parameter N, default 9: number of samples per frame.
REQ-002 Parameter W, default 8: sample and delta width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port in_data, input, W: delta value, unsigned mod 2^W.
REQ-006 Port in_first, input, 1: marks the delta as the first of a frame.
REQ-007 Port in_valid, input, 1: in_data and in_first are valid.
REQ-008 Port in_ready, output, 1: the block can accept a delta this cycle.
REQ-009 Port out1..out9, output, W each: reconstructed samples in frame order.
REQ-010 Port out_valid, output, 1: out1..out9 hold a complete frame.
REQ-011 Port out_ready, input, 1: the downstream side accepts the frame.
REQ-012 Port frame_err, output, 1: one-cycle pulse when a frame is restarted before completion.

Function
REQ-013 The block shall invert the successive-difference encoding: sample1 = delta1; samplek = sample(k-1) + deltak mod 2^W, for k = 2..N.
REQ-014 A delta is accepted only on a cycle where in_valid and in_ready are both 1.
REQ-015 The FSM has two states: COLLECT (in_ready=1, out_valid=0) and PRESENT (in_ready=0, out_valid=1).
REQ-016 In COLLECT, a 4-bit index counts accepted deltas from 0 to N-1.
REQ-017 Each accepted delta writes sample[idx] = acc + in_data and sets acc to that same sum.
REQ-018 When idx=0, or when in_first=1, the accepted delta shall write sample[0] = in_data and set acc = in_data.
REQ-019 When in_first=1 is accepted with idx≠0, the block restarts the frame at idx=1 and pulses frame_err for exactly one cycle.
REQ-020 When in_first=0 is accepted with idx=0, the block accepts the delta as the first of a new frame and does not flag an error.
REQ-021 Accepting the Nth delta (idx=N-1) moves the FSM to PRESENT on the next edge: out_valid rises one cycle after the final handshake.
REQ-022 In PRESENT, out1..out9 and out_valid shall hold stable until out_ready=1.
REQ-023 When out_valid=1 and out_ready=1, the FSM returns to COLLECT with idx=0 on the next edge; out1..out9 keep their values.
REQ-024 in_valid is ignored in PRESENT; no delta is lost or consumed.
REQ-025 All additions wrap mod 2^W; there is no saturation and no carry output.

Reset
REQ-026 While rst_n=0 at a clock edge: state=COLLECT, idx=0, acc=0, out1..out9=0, out_valid=0, frame_err=0.
REQ-027 in_ready shall be 0 during any cycle with rst_n=0, and 1 on the first cycle after release.
REQ-028 A reset in mid-frame or in PRESENT discards the partial or held frame with no error pulse.

Structure
REQ-029 A shared package holds the N and W defaults and the FSM state enumeration (COLLECT, PRESENT).
REQ-030 The encoder successive_difference and this decoder both import the same package.
REQ-031 The sample register bank is one sub-module, sample_bank: N x W registers with indexed write and parallel read.

Verification
REQ-032 Deltas 1,2,1,1,4,248,0,0,0 (first flagged) -> out1..9 = 1,3,4,5,9,1,1,1,1, out_valid high one cycle after the 9th handshake.
REQ-033 Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no deltas consumed; then out_ready=1 -> return to COLLECT.
REQ-034 Deltas 200,100,... -> out2=44 (wrap mod 256).
REQ-035 in_first=1 on the 4th delta of a frame -> frame_err pulses once, and the new frame reconstructs correctly from that delta.
REQ-036 rst_n=0 after 5 accepted deltas -> all outputs 0 next cycle; a full fresh frame then decodes correctly.
REQ-037 Loopback: random 9-byte frames through successive_difference then this block -> outputs equal the original inputs for 1000 frames.
